// File: rtl/alu_pkg.sv
// Encodings shared by the ALU and its multi-precision sequencer:
// flag bit positions, FuncOp codes and the sequencer FSM states.
package alu_pkg;

    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 3;

    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_EMIT   = 3'd3,
        ST_FINISH = 3'd4
    } seq_state_t;

    // Flag vector carrying only a carry/borrow bit, as fed to the ALU IFlags.
    function automatic logic [3:0] carry_flags(input logic carry);
        logic [3:0] flags;
        flags         = '0;
        flags[FLAG_C] = carry;
        return flags;
    endfunction

endpackage

// File: rtl/alu_seq_watchdog.sv
// Stall watchdog for alu_sequencer; only built when ALU_SEQ_TIMEOUT_EN is defined.
// expired rises combinationally on the stall cycle that completes TimeoutCycles stalls.
`ifdef ALU_SEQ_TIMEOUT_EN
module alu_seq_watchdog #(
    parameter int TimeoutCycles = 255
) (
    input  logic Clock,
    input  logic Reset,
    input  logic stall,
    output logic expired
);

    localparam int CW = $clog2(TimeoutCycles + 1);

    logic [CW-1:0] count;

    assign expired = stall && (count == CW'(TimeoutCycles - 1));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count <= '0;
        end else if (stall && !expired) begin
            count <= count + 1'b1;
        end else begin
            count <= '0;
        end
    end

endmodule
`endif

// File: rtl/alu_sequencer.sv
// Multi-precision add/subtract controller that chains an N-word operation through the ALU.
// Optional stall timeout with abort: define ALU_SEQ_TIMEOUT_EN.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int BitWidth      = 8,
    parameter int CntWidth      = 2,
    parameter int TimeoutCycles = 255
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic                Sub,
    input  logic [CntWidth-1:0] Words,
    input  logic                CarryIn,
    output logic                Busy,
    input  logic                InValid,
    output logic                InReady,
    input  logic [BitWidth-1:0] InA,
    input  logic [BitWidth-1:0] InB,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [BitWidth-1:0] OutY,
    output logic                OutLast,
    output logic                Done,
    output logic                Abort,
    output logic [3:0]          FlagsOut,
    output logic [BitWidth-1:0] AluA,
    output logic [BitWidth-1:0] AluB,
    output logic [3:0]          AluFuncOp,
    output logic [3:0]          AluIFlags,
    output logic                AluOE,
    input  logic [BitWidth-1:0] AluY,
    input  logic [3:0]          AluOFlags
);

    if (TimeoutCycles < 1) begin : g_bad_timeout
        $error("alu_sequencer: TimeoutCycles must be at least 1");
    end

    seq_state_t          state, state_next;
    logic                sub_q;
    logic [CntWidth-1:0] words_q;
    logic [CntWidth-1:0] cnt_q;
    logic                carry_q;
    logic                zacc_q;
    logic                c_q, v_q, n_q;
    logic [3:0]          final_flags;
    logic                fetch_hs, emit_hs, last_word, expired;

    assign fetch_hs  = (state == ST_FETCH) && InValid;
    assign emit_hs   = (state == ST_EMIT) && OutReady;
    assign last_word = (cnt_q == words_q);

`ifdef ALU_SEQ_TIMEOUT_EN
    logic stall;
    logic abort_q;

    assign stall = ((state == ST_FETCH) && !InValid) || ((state == ST_EMIT) && !OutReady);
    assign Abort = (state == ST_FINISH) && abort_q;

    alu_seq_watchdog #(
        .TimeoutCycles(TimeoutCycles)
    ) u_watchdog (
        .Clock  (Clock),
        .Reset  (Reset),
        .stall  (stall),
        .expired(expired)
    );
`else
    assign expired = 1'b0;
    assign Abort   = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (Start) state_next = ST_FETCH;
            ST_FETCH: begin
                if (fetch_hs)     state_next = ST_EXEC;
                else if (expired) state_next = ST_FINISH;
            end
            ST_EXEC:   state_next = ST_EMIT;
            ST_EMIT: begin
                if (emit_hs)      state_next = last_word ? ST_FINISH : ST_FETCH;
                else if (expired) state_next = ST_FINISH;
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        Busy      = (state != ST_IDLE);
        InReady   = (state == ST_FETCH);
        OutValid  = (state == ST_EMIT);
        OutLast   = OutValid && last_word;
        Done      = (state == ST_FINISH);
        AluOE     = (state == ST_EXEC);
        AluFuncOp = '0;
        AluIFlags = '0;
        if (AluOE) begin
            AluFuncOp = sub_q ? OP_SUB : OP_ADD;
            AluIFlags = carry_flags(carry_q);
        end
    end

    always_comb begin
        final_flags         = '0;
        final_flags[FLAG_C] = c_q;
        final_flags[FLAG_V] = v_q;
        final_flags[FLAG_N] = n_q;
        final_flags[FLAG_Z] = zacc_q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sub_q    <= 1'b0;
            words_q  <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b1;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            n_q      <= 1'b0;
            AluA     <= '0;
            AluB     <= '0;
            OutY     <= '0;
            FlagsOut <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
            abort_q  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        sub_q   <= Sub;
                        words_q <= Words;
                        carry_q <= CarryIn;
                        zacc_q  <= 1'b1;
                        cnt_q   <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
                        abort_q <= 1'b0;
`endif
                    end
                end
                ST_FETCH: begin
                    if (fetch_hs) begin
                        AluA <= InA;
                        AluB <= InB;
                    end
                end
                ST_EXEC: begin
                    // C/V/N are overwritten every word, so the last word's flags survive.
                    OutY    <= AluY;
                    carry_q <= AluOFlags[FLAG_C];
                    zacc_q  <= zacc_q & AluOFlags[FLAG_Z];
                    c_q     <= AluOFlags[FLAG_C];
                    v_q     <= AluOFlags[FLAG_V];
                    n_q     <= AluOFlags[FLAG_N];
                end
                ST_EMIT: begin
                    if (emit_hs) begin
                        if (last_word) FlagsOut <= final_flags;
                        else           cnt_q    <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
`ifdef ALU_SEQ_TIMEOUT_EN
            if (expired) begin
                FlagsOut <= '0;
                abort_q  <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a behavioural ALU drives AluY/AluOFlags, a whole-number
// reference model predicts every result word, carry-in and final flag set.
module tb_alu_sequencer;
    import alu_pkg::*;

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0, Sub = 1'b0, CarryIn = 1'b0;
    logic [1:0] Words = '0;
    logic       Busy, InReady, OutValid, OutLast, Done, Abort, AluOE;
    logic       InValid = 1'b0, OutReady = 1'b0;
    logic [7:0] InA = '0, InB = '0, OutY, AluA, AluB, AluY;
    logic [3:0] FlagsOut, AluFuncOp, AluIFlags, AluOFlags;

    alu_sequencer #(.BitWidth(8), .CntWidth(2), .TimeoutCycles(TO)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Sub(Sub), .Words(Words),
        .CarryIn(CarryIn), .Busy(Busy), .InValid(InValid), .InReady(InReady),
        .InA(InA), .InB(InB), .OutValid(OutValid), .OutReady(OutReady), .OutY(OutY),
        .OutLast(OutLast), .Done(Done), .Abort(Abort), .FlagsOut(FlagsOut),
        .AluA(AluA), .AluB(AluB), .AluFuncOp(AluFuncOp), .AluIFlags(AluIFlags),
        .AluOE(AluOE), .AluY(AluY), .AluOFlags(AluOFlags)
    );

    always #5 Clock = ~Clock;

    // Behavioural 8-bit ALU: C is carry for add and borrow for subtract.
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum   = '0;
        AluY      = '0;
        AluOFlags = '0;
        if (AluOE) begin
            if (AluFuncOp == OP_SUB) alu_sum = {1'b0, AluA} - {1'b0, AluB} - 9'(AluIFlags[FLAG_C]);
            else                     alu_sum = {1'b0, AluA} + {1'b0, AluB} + 9'(AluIFlags[FLAG_C]);
            AluY              = alu_sum[7:0];
            AluOFlags[FLAG_C] = alu_sum[8];
            AluOFlags[FLAG_Z] = (alu_sum[7:0] == 8'h00);
            AluOFlags[FLAG_N] = alu_sum[7];
            AluOFlags[FLAG_V] = (AluFuncOp == OP_SUB) ? ((AluA[7] != AluB[7]) && (alu_sum[7] != AluA[7]))
                                                      : ((AluA[7] == AluB[7]) && (alu_sum[7] != AluA[7]));
        end
    end

    typedef struct { logic [7:0] y; logic last; } word_exp_t;
    typedef struct { logic [3:0] op; logic carry; logic [7:0] a; logic [7:0] b; } exec_exp_t;

    word_exp_t  word_q[$];
    exec_exp_t  exec_q[$];
    logic [4:0] done_q[$];   // {abort, flags}
    int         n_cmp = 0, n_bad = 0;
    int         ready_pct = 100;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: treat the operands as whole (nwm1+1)*8-bit numbers.
    task automatic push_expect(input bit sub, input int nwm1, input bit cin,
                               input logic [63:0] a, input logic [63:0] b);
        int          w;
        logic [63:0] mask, am, bm, r, lo, ci;
        logic        c, v, n, z;
        logic [3:0]  f;
        w    = 8 * (nwm1 + 1);
        mask = (64'd1 << w) - 64'd1;
        am   = a & mask;
        bm   = b & mask;
        for (int k = 0; k <= nwm1; k++) begin
            lo = (64'd1 << (8 * k)) - 64'd1;
            if (sub) ci = 64'((am & lo) < ((bm & lo) + 64'(cin)));
            else     ci = ((am & lo) + (bm & lo) + 64'(cin)) >> (8 * k);
            exec_q.push_back('{sub ? OP_SUB : OP_ADD, ci[0], am[8*k +: 8], bm[8*k +: 8]});
        end
        if (sub) begin r = am - bm - 64'(cin); c = (am < bm + 64'(cin)); end
        else     begin r = am + bm + 64'(cin); c = r[w];                 end
        r = r & mask;
        n = r[w-1];
        v = sub ? ((am[w-1] != bm[w-1]) && (n != am[w-1])) : ((am[w-1] == bm[w-1]) && (n != am[w-1]));
        z = (r == 64'd0);
        for (int k = 0; k <= nwm1; k++) word_q.push_back('{r[8*k +: 8], k == nwm1});
        f = '0;
        f[FLAG_C] = c; f[FLAG_V] = v; f[FLAG_N] = n; f[FLAG_Z] = z;
        done_q.push_back({1'b0, f});
    endtask

    task automatic flush();
        word_q.delete(); exec_q.delete(); done_q.delete();
    endtask

    // Monitor: compares whatever the DUT presents against the queue heads.
    always @(negedge Clock) begin
        if (!Reset) begin
            if (OutValid) begin
                check("emit_alu_oe", AluOE, 1'b0);
                if (word_q.size() == 0) check("out_unexpected", OutValid, 1'b0);
                else begin
                    check("out_y", OutY, word_q[0].y);
                    check("out_last", OutLast, word_q[0].last);
                    if (OutReady) void'(word_q.pop_front());
                end
            end
            if (AluOE) begin
                if (exec_q.size() == 0) check("exec_unexpected", AluOE, 1'b0);
                else begin
                    check("alu_funcop", AluFuncOp, exec_q[0].op);
                    check("alu_iflags", AluIFlags, carry_flags(exec_q[0].carry));
                    check("alu_a", AluA, exec_q[0].a);
                    check("alu_b", AluB, exec_q[0].b);
                    void'(exec_q.pop_front());
                end
            end else begin
                check("alu_ctrl_idle", {AluFuncOp, AluIFlags}, 8'h00);
            end
            if (Done) begin
                if (done_q.size() == 0) check("done_unexpected", Done, 1'b0);
                else begin
                    check("flags_out", FlagsOut, done_q[0][3:0]);
                    check("abort", Abort, done_q[0][4]);
                    void'(done_q.pop_front());
                end
            end else begin
                check("abort_idle", Abort, 1'b0);
            end
            if (!Busy) check("idle_in_ready", InReady, 1'b0);
        end
    end

    initial begin
        forever begin
            @(posedge Clock); #1;
            OutReady = ($urandom_range(0, 99) < ready_pct);
        end
    end

    task automatic wait_in_ready(output bit got);
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge Clock);
            if (InReady) begin got = 1'b1; break; end
        end
        if (!got) check("in_ready_wait", InReady, 1'b1);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge Clock);
            if (!Busy) begin idle = 1'b1; break; end
        end
        if (!idle) begin
            check("idle_wait", Busy, 1'b0);
            @(posedge Clock); #1; Reset = 1'b1;
            @(posedge Clock); #1; Reset = 1'b0;
            flush();
        end
        check("words_drained", word_q.size(), 0);
        check("done_drained", done_q.size(), 0);
    endtask

    task automatic run_cmd(input bit sub, input int nwm1, input bit cin,
                           input logic [63:0] a, input logic [63:0] b,
                           input int max_gap, input bit poke_start, input int reset_word);
        bit got;
        push_expect(sub, nwm1, cin, a, b);
        @(posedge Clock); #1;
        Start = 1'b1; Sub = sub; Words = 2'(nwm1); CarryIn = cin;
        InValid = 1'b1; InA = ~a[7:0]; InB = 8'hA5;   // offered in IDLE, must not be taken
        @(posedge Clock); #1;
        Start = 1'b0; InValid = 1'b0;
        Sub = 1'($urandom); Words = 2'($urandom); CarryIn = 1'($urandom);
        for (int k = 0; k <= nwm1; k++) begin
            repeat ($urandom_range(0, max_gap)) begin
                InA = 8'($urandom); InB = 8'($urandom);
                @(posedge Clock); #1;
            end
            InA = a[8*k +: 8]; InB = b[8*k +: 8]; InValid = 1'b1;
            wait_in_ready(got);
            if (!got) begin InValid = 1'b0; flush(); return; end
            @(posedge Clock); #1;
            InValid = 1'b0;
            if (k == reset_word) begin
                Reset = 1'b1;
                @(posedge Clock); #1;
                Reset = 1'b0;
                flush();
                return;
            end
            if (poke_start && k < nwm1) begin
                Start = 1'b1; Sub = ~sub; Words = 2'd0; CarryIn = ~cin;
                @(posedge Clock); #1;
                Start = 1'b0;
            end
        end
        wait_idle();
    endtask

    initial begin
        int lat;
        bit got;
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        int lat;
        bit got;
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        check("reset_outputs",
              {Busy, InReady, OutValid, OutY, OutLast, Done, Abort, FlagsOut,
               AluA, AluB, AluFuncOp, AluIFlags, AluOE}, '0);

        // Directed cases.
        run_cmd(1'b0, 1, 1'b0, 64'h12FF, 64'h0001, 0, 1'b0, -1);
        run_cmd(1'b0, 1, 1'b0, 64'hFF00, 64'h0100, 0, 1'b0, -1);
        run_cmd(1'b0, 3, 1'b0, 64'hFFFF_FFFF, 64'h0000_0001, 0, 1'b0, -1);
        run_cmd(1'b1, 3, 1'b0, 64'h0000_0000, 64'h0000_0001, 1, 1'b0, -1);

        // Latency of a single word with no stalls.
        fork
            run_cmd(1'b0, 0, 1'b1, 64'h7F, 64'h00, 0, 1'b0, -1);
            begin
                lat = -1;
                wait_in_ready(got);
                for (int i = 1; i <= 20; i++) begin
                    @(negedge Clock);
                    if (Done) begin lat = i; break; end
                end
                check("done_latency_edges_after_fetch", lat, 3);
            end
        join

        // Consumer stall in EMIT plus a Start pulse that must be ignored.
        ready_pct = 0;
        fork
            run_cmd(1'b1, 2, 1'b1, 64'($urandom), 64'($urandom), 0, 1'b1, -1);
            begin
                for (int i = 0; i < 400 && !OutValid; i++) @(negedge Clock);
                repeat (5) begin
                    @(negedge Clock);
                    check("stall_valid", OutValid, 1'b1);
                    check("stall_no_fetch", InReady, 1'b0);
                end
                ready_pct = 100;
            end
        join

        // Reset in EXEC of word 1 of 3, then a clean zero-result command.
        run_cmd(1'b0, 2, 1'b0, 64'h0102_0304, 64'h0506_0708, 0, 1'b0, 1);
        repeat (3) begin
            @(negedge Clock);
            check("post_reset_idle", {Busy, OutValid, Done}, 3'b000);
        end
        run_cmd(1'b1, 1, 1'b0, 64'h1234, 64'h1234, 0, 1'b0, -1);

`ifdef ALU_SEQ_TIMEOUT_EN
        done_q.push_back(5'b1_0000);
        @(posedge Clock); #1;
        Start = 1'b1; Sub = 1'b0; Words = 2'd1; CarryIn = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        wait_in_ready(got);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge Clock);
            if (Done) begin lat = i; break; end
        end
        check("timeout_latency", lat, TO);
        @(negedge Clock);
        check("timeout_idle", Busy, 1'b0);
        check("timeout_done_drained", done_q.size(), 0);
`endif

        // Randomized traffic with input gaps and consumer back-pressure.
        ready_pct = 75;
        for (int t = 0; t < 40; t++) begin
            run_cmd(1'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
                    {$urandom, $urandom}, {$urandom, $urandom}, 3, 1'($urandom), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
